// File: rtl/full_adder_pkg.sv
// Shared constants for arithmetic leaf cells.
// Holds the supported operand width bound.
package full_adder_pkg;

  localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder cell: the link in the ripple-carry chain.
// Latency: purely combinational. Backpressure: none.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {cout, sum} = a + b + cin.
// Latency: 1 cycle from in_valid to out_valid.
// Backpressure: none; accepts a new operand set every cycle.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("full_adder: WIDTH out of range");
  end

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_nxt;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_bit u_bit (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum_nxt[i]),
      .cout (c[i+1])
    );
  end

  // Result registers only load on in_valid, so idle-cycle garbage on a/b/cin never reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_nxt;
        cout <= c[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1 (truth table) and WIDTH=8 (corners, random).
module tb_full_adder;

  logic clk;
  logic rst_n;

  logic       a1, b1, cin1, iv1;
  logic       sum1, cout1, ov1;

  logic [7:0] a8, b8, sum8;
  logic       cin8, iv8, cout8, ov8;

  int total = 0;
  int bad   = 0;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .in_valid  (iv1),
    .sum       (sum1),
    .cout      (cout1),
    .out_valid (ov1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .in_valid  (iv8),
    .sum       (sum8),
    .cout      (cout8),
    .out_valid (ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       a;
    logic       b;
    logic       cin;
    logic [1:0] exp;
  } vec1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec8_t;

  vec1_t tbl1[8];
  vec8_t tbl8[3];

  // Reference model state: last accepted result of the 8-bit adder.
  logic [8:0] model8;
  logic       model_ov8;

  initial begin
    tbl1[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
    tbl1[1] = '{1'b0, 1'b0, 1'b1, 2'b01};
    tbl1[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
    tbl1[3] = '{1'b0, 1'b1, 1'b1, 2'b10};
    tbl1[4] = '{1'b1, 1'b0, 1'b0, 2'b01};
    tbl1[5] = '{1'b1, 1'b0, 1'b1, 2'b10};
    tbl1[6] = '{1'b1, 1'b1, 1'b0, 2'b10};
    tbl1[7] = '{1'b1, 1'b1, 1'b1, 2'b11};

    tbl8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl8[2] = '{8'h5A, 8'h25, 1'b0, 8'h7F, 1'b0};

    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0; iv1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; iv8 = 1'b0;
    model8 = '0;
    model_ov8 = 1'b0;

    repeat (3) after_edge();
    check("rst_sum1", {63'd0, sum1}, 64'd0);
    check("rst_cout1", {63'd0, cout1}, 64'd0);
    check("rst_ov1", {63'd0, ov1}, 64'd0);
    check("rst_sum8", {56'd0, sum8}, 64'd0);
    check("rst_ov8", {63'd0, ov8}, 64'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 truth table, one vector per cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = tbl1[i].a; b1 = tbl1[i].b; cin1 = tbl1[i].cin; iv1 = 1'b1;
      after_edge();
      check($sformatf("tt%0d_sum_cout", i), {62'd0, cout1, sum1}, {62'd0, tbl1[i].exp});
      check($sformatf("tt%0d_ov", i), {63'd0, ov1}, 64'd1);
    end

    // Idle with X operands: outputs hold 11, out_valid drops.
    @(negedge clk);
    iv1 = 1'b0; a1 = 1'bx; b1 = 1'bx; cin1 = 1'bx;
    repeat (3) after_edge();
    check("hold_sum_cout", {62'd0, cout1, sum1}, 64'd3);
    check("hold_ov", {63'd0, ov1}, 64'd0);

    // WIDTH=8 directed corners.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a8 = tbl8[i].a; b8 = tbl8[i].b; cin8 = tbl8[i].cin; iv8 = 1'b1;
      after_edge();
      check($sformatf("w8_%0d_sum", i), {56'd0, sum8}, {56'd0, tbl8[i].exp_sum});
      check($sformatf("w8_%0d_cout", i), {63'd0, cout8}, {63'd0, tbl8[i].exp_cout});
      check($sformatf("w8_%0d_ov", i), {63'd0, ov8}, 64'd1);
    end
    model8 = {1'b0, tbl8[2].exp_sum};

    // Back-to-back random traffic, valid mostly high.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
      iv8  = ($urandom_range(0, 3) != 0);
      if (iv8)
        model8 = 9'(int'(a8) + int'(b8) + int'(cin8));
      model_ov8 = iv8;
      after_edge();
      check("rnd_sum", {56'd0, sum8}, {56'd0, model8[7:0]});
      check("rnd_cout", {63'd0, cout8}, {63'd0, model8[8]});
      check("rnd_ov", {63'd0, ov8}, {63'd0, model_ov8});
    end

    // Mid-stream asynchronous reset while both outputs are valid.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1; iv1 = 1'b1;
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; iv8 = 1'b1;
    after_edge();
    check("pre_rst_ov1", {63'd0, ov1}, 64'd1);
    check("pre_rst_ov8", {63'd0, ov8}, 64'd1);
    check("pre_rst_sum8", {55'd0, cout8, sum8}, 64'h101);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sum1", {63'd0, sum1}, 64'd0);
    check("arst_cout1", {63'd0, cout1}, 64'd0);
    check("arst_ov1", {63'd0, ov1}, 64'd0);
    check("arst_sum8", {56'd0, sum8}, 64'd0);
    check("arst_cout8", {63'd0, cout8}, 64'd0);
    check("arst_ov8", {63'd0, ov8}, 64'd0);

    @(negedge clk);
    iv1 = 1'b0; iv8 = 1'b0;
    rst_n = 1'b1;
    repeat (2) after_edge();
    check("post_rst_ov1", {63'd0, ov1}, 64'd0);
    check("post_rst_ov8", {63'd0, ov8}, 64'd0);
    check("post_rst_sum8", {55'd0, cout8, sum8}, 64'd0);

    // First valid after reset needs a fresh in_valid.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; iv8 = 1'b1;
    after_edge();
    check("first_sum8", {55'd0, cout8, sum8}, 64'h47);
    check("first_ov8", {63'd0, ov8}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/full_adder.md
Name: full_adder

Overview:
- Registered binary full adder: sum = a + b + cin over WIDTH bits, with carry-out.
- Default WIDTH=1 gives the classic single-bit full adder truth table.
- Used as a leaf arithmetic cell in datapaths that need a clocked, reset-clean add with a valid qualifier.
- Combinational ripple-carry chain of 1-bit cells, followed by one output register stage.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- sum  output  WIDTH  registered sum bits (a + b + cin) mod 2^WIDTH
- cout  output  1  registered carry-out, bit WIDTH of a + b + cin
- a  input  WIDTH  addend A, unsigned
- b  input  WIDTH  addend B, unsigned
- cin  input  1  carry-in into bit 0
- in_valid  input  1  a/b/cin qualified this cycle
- out_valid  output  1  sum/cout hold a fresh result

Behaviour:
- Reset is asynchronous and active-low: when rst_n=0, sum, cout and out_valid go to 0 immediately, independent of clk. Release is synchronous to the next rising clk edge.
- Arithmetic: {cout, sum} = a + b + cin, computed at WIDTH+1 bits with no truncation before the register.
- Bit i sum = a[i] ^ b[i] ^ c[i].
- Bit i carry: c[i+1] = (a[i]&b[i]) | (c[i]&(a[i]^b[i])), with c[0] = cin and cout = c[WIDTH].
- Latency is exactly 1 cycle. If in_valid=1 at rising edge k, then after edge k sum/cout hold the result for the operands sampled at edge k, and out_valid=1.
- If in_valid=0 at an edge: sum/cout hold their previous values and out_valid=0.
- No backpressure. A new operand set may be accepted every cycle, giving throughput 1/cycle.
- Wrap-around: an all-ones a and b with cin=1 give sum = all ones and cout=1. Overflow is reported only via cout; there is no saturation.
- Reset asserted mid-stream discards the in-flight result. The first out_valid after reset release requires a new in_valid.
- X on a/b/cin while in_valid=0 must not propagate to the outputs.
- No combinational path from inputs to outputs.

Decomposition:
- No shared package is required. If one already exists for arithmetic cells, a localparam for the maximum WIDTH (64) may live there.
- One sub-module, full_adder_bit: purely combinational 1-bit cell (a, b, cin -> sum, cout), instantiated WIDTH times via generate to form the ripple chain.
- Top level owns the output registers, out_valid and reset logic.

Test Plan:
- WIDTH=1, reset low then released, in_valid=1 each cycle, applying all 8 {a,b,cin} combinations in order 000..111 -> after 1 cycle each, {cout,sum} = 00,01,01,10,01,10,10,11 with out_valid=1.
- WIDTH=1, in_valid=0 after the 111 vector -> sum=1 and cout=1 hold, out_valid=0; driving a/b to X does not disturb the outputs.
- WIDTH=8, a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1; then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- WIDTH=8, a=8'h5A, b=8'h25, cin=0 -> sum=8'h7F, cout=0 one cycle later; back-to-back random vectors checked against a reference model every cycle.
- Assert rst_n=0 between clock edges while out_valid=1 -> sum, cout and out_valid drop to 0 immediately. After release with no in_valid, out_valid stays 0.
